// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the 7-segment bus snooper.
// Active-low segment order is {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic [0:0] {
        SCAN = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t GLYPH_0 = 7'b1000000;
    localparam seg_t GLYPH_1 = 7'b1111001;
    localparam seg_t GLYPH_2 = 7'b0100100;
    localparam seg_t GLYPH_3 = 7'b0110000;
    localparam seg_t GLYPH_4 = 7'b0011001;
    localparam seg_t GLYPH_5 = 7'b0010010;
    localparam seg_t GLYPH_6 = 7'b0000010;
    localparam seg_t GLYPH_7 = 7'b1111000;
    localparam seg_t GLYPH_8 = 7'b0000000;
    localparam seg_t GLYPH_9 = 7'b0010000;
    localparam seg_t GLYPH_A = 7'b0001000;
    localparam seg_t GLYPH_B = 7'b0000011;
    localparam seg_t GLYPH_C = 7'b1000110;
    localparam seg_t GLYPH_D = 7'b0100001;
    localparam seg_t GLYPH_E = 7'b0000110;
    localparam seg_t GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph -> nibble decoder; unknown patterns flag err_o.
// Ports: seg_i (active-low pattern), nibble_o, err_o, blank_o.
// With BLANK_DETECT_EN defined, the all-off pattern is a legal blank.
import seg_pkg::*;

module seg7_decode (
    input  seg_t       seg_i,
    output logic [3:0] nibble_o,
    output logic       err_o,
    output logic       blank_o
);

    always_comb begin
        nibble_o = 4'h0;
        err_o    = 1'b0;
        blank_o  = 1'b0;
        case (seg_i)
            GLYPH_0: nibble_o = 4'h0;
            GLYPH_1: nibble_o = 4'h1;
            GLYPH_2: nibble_o = 4'h2;
            GLYPH_3: nibble_o = 4'h3;
            GLYPH_4: nibble_o = 4'h4;
            GLYPH_5: nibble_o = 4'h5;
            GLYPH_6: nibble_o = 4'h6;
            GLYPH_7: nibble_o = 4'h7;
            GLYPH_8: nibble_o = 4'h8;
            GLYPH_9: nibble_o = 4'h9;
            GLYPH_A: nibble_o = 4'hA;
            GLYPH_B: nibble_o = 4'hB;
            GLYPH_C: nibble_o = 4'hC;
            GLYPH_D: nibble_o = 4'hD;
            GLYPH_E: nibble_o = 4'hE;
            GLYPH_F: nibble_o = 4'hF;
            default: err_o    = 1'b1;
        endcase
`ifdef BLANK_DETECT_EN
        if (seg_i == SEG_BLANK) begin
            err_o   = 1'b0;
            blank_o = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed active-low 7-seg bus and rebuilds the hex frame.
// Ports: clk, rst_n (async, active-low), seg_n, dig_sel in;
//        frame_value/err/valid, overrun out; frame_ready in.
// Option: BLANK_DETECT_EN adds frame_blank and accepts 1111111.
import seg_pkg::*;

module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] frame_value,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
`ifdef BLANK_DETECT_EN
    output logic [NUM_DIGITS-1:0]   frame_blank,
`endif
    output logic                    overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    seg_t                    r_seg_q, p_seg_q;
    logic [NUM_DIGITS-1:0]   r_dig_q, p_dig_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
    logic [NUM_DIGITS-1:0]   sh_err_q, sh_err_d;
    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    state_t                  state_q, state_d;
    logic                    ovr_q, ovr_d;

    logic                    onehot, dig_chg, smp_chg;
    logic                    accept, publish, load;
    logic [NUM_DIGITS-1:0]   acc_bits;
    logic [3:0]              dec_nib;
    logic                    dec_err;

`ifdef BLANK_DETECT_EN
    logic                    dec_blank;
    logic [NUM_DIGITS-1:0]   sh_blk_q, sh_blk_d;
    logic [NUM_DIGITS-1:0]   blk_q, blk_d;
`endif

    seg7_decode u_dec (
        .seg_i    (r_seg_q),
        .nibble_o (dec_nib),
        .err_o    (dec_err),
`ifdef BLANK_DETECT_EN
        .blank_o  (dec_blank)
`else
        .blank_o  ()
`endif
    );

    // Stability tracking and once-per-selection acceptance.
    always_comb begin
        onehot  = $onehot(r_dig_q);
        dig_chg = (r_dig_q != p_dig_q);
        smp_chg = dig_chg || (r_seg_q != p_seg_q);
        cnt_d   = cnt_q;
        if (!onehot) begin
            cnt_d = '0;
        end else if (smp_chg) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        // done_q only blocks while the same digit stays selected
        accept   = onehot && (cnt_d == CNT_MAX)
                   && !(done_q && !dig_chg);
        done_d   = accept || (done_q && !dig_chg);
        acc_bits = accept ? r_dig_q : '0;
        publish  = &mask_q;
        mask_d   = (publish ? '0 : mask_q) | acc_bits;
    end

    always_comb begin
        sh_val_d = sh_val_q;
        sh_err_d = sh_err_q;
`ifdef BLANK_DETECT_EN
        sh_blk_d = sh_blk_q;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc_bits[i]) begin
                sh_val_d[4*i +: 4] = dec_nib;
                sh_err_d[i]        = dec_err;
`ifdef BLANK_DETECT_EN
                sh_blk_d[i]        = dec_blank;
`endif
            end
        end
    end

    // Output FSM: a publish in HOLD either replaces the frame
    // (consumer taking the old one this cycle) or is dropped.
    always_comb begin
        state_d = state_q;
        ovr_d   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            SCAN: begin
                if (publish) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (publish) begin
                    if (frame_ready) load  = 1'b1;
                    else             ovr_d = 1'b1;
                end else if (frame_ready) begin
                    state_d = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
        val_d = load ? sh_val_q : val_q;
        err_d = load ? sh_err_q : err_q;
`ifdef BLANK_DETECT_EN
        blk_d = load ? sh_blk_q : blk_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_q  <= '0;
            p_seg_q  <= '0;
            r_dig_q  <= '0;
            p_dig_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            mask_q   <= '0;
            sh_val_q <= '0;
            sh_err_q <= '0;
            val_q    <= '0;
            err_q    <= '0;
            state_q  <= SCAN;
            ovr_q    <= 1'b0;
        end else begin
            r_seg_q  <= seg_n;
            p_seg_q  <= r_seg_q;
            r_dig_q  <= dig_sel;
            p_dig_q  <= r_dig_q;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            mask_q   <= mask_d;
            sh_val_q <= sh_val_d;
            sh_err_q <= sh_err_d;
            val_q    <= val_d;
            err_q    <= err_d;
            state_q  <= state_d;
            ovr_q    <= ovr_d;
        end
    end

`ifdef BLANK_DETECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_blk_q <= '0;
            blk_q    <= '0;
        end else begin
            sh_blk_q <= sh_blk_d;
            blk_q    <= blk_d;
        end
    end

    assign frame_blank = blk_q;
`endif

    assign frame_value = val_q;
    assign frame_err   = err_q;
    assign frame_valid = (state_q == HOLD);
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with a pin-level reference model.
// Build with BLANK_DETECT_EN to cover the blank-digit option.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_sel = 4'h0;
    logic        frame_ready = 1'b0;
    logic [15:0] frame_value;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        overrun;
`ifdef BLANK_DETECT_EN
    logic [3:0]  frame_blank;
`endif

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .dig_sel     (dig_sel),
        .frame_value (frame_value),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
`ifdef BLANK_DETECT_EN
        .frame_blank (frame_blank),
`endif
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ovr_seen = 0;

    logic [6:0] glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          run_len;
    logic [6:0]  last_seg;
    logic [3:0]  last_dig;
    bit          dig_done;
    logic [3:0]  m_mask;
    logic [15:0] sh_val;
    logic [3:0]  sh_err, sh_blk;
    logic [15:0] m_val;
    logic [3:0]  m_err, m_blk;
    bit          m_valid, m_ovr;

    task automatic mdec(input logic [6:0] p, output logic [3:0] n,
                        output logic e, output logic b);
        n = 4'h0;
        e = 1'b1;
        b = 1'b0;
        for (int g = 0; g < 16; g++)
            if (glyph[g] == p) begin
                n = 4'(g);
                e = 1'b0;
            end
`ifdef BLANK_DETECT_EN
        if (p == 7'h7F) begin
            e = 1'b0;
            b = 1'b1;
        end
`endif
    endtask

    task automatic mreset();
        run_len  = 0;
        last_seg = '0;
        last_dig = '0;
        dig_done = 0;
        m_mask   = '0;
        sh_val   = '0;
        sh_err   = '0;
        sh_blk   = '0;
        m_val    = '0;
        m_err    = '0;
        m_blk    = '0;
        m_valid  = 0;
        m_ovr    = 0;
    endtask

    // One clock edge: pins p_seg/p_dig are the values sampled now.
    task automatic mstep(input logic [6:0] p_seg, input logic [3:0] p_dig,
                         input logic rdy);
        bit pub, acc;
        logic [3:0] n;
        logic e, b;
        pub = (m_mask == 4'hF);
        acc = ($countones(last_dig) == 1) && (run_len == SC) && !dig_done;
        m_ovr = 0;
        if (pub) begin
            if (!m_valid || rdy) begin
                m_val   = sh_val;
                m_err   = sh_err;
                m_blk   = sh_blk;
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (pub) m_mask = '0;
        if (acc) begin
            mdec(last_seg, n, e, b);
            for (int i = 0; i < ND; i++)
                if (last_dig[i]) begin
                    sh_val[4*i +: 4] = n;
                    sh_err[i] = e;
                    sh_blk[i] = b;
                    m_mask[i] = 1'b1;
                end
            dig_done = 1;
        end
        if (p_dig != last_dig) dig_done = 0;
        if (p_seg == last_seg && p_dig == last_dig) run_len++;
        else run_len = 1;
        last_seg = p_seg;
        last_dig = p_dig;
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk);
            if (!rst_n) mreset();
            else mstep(seg_n, dig_sel, frame_ready);
            @(negedge clk);
            if (!rst_n) mreset();
            check("value", frame_value, m_val);
            check("err", frame_err, m_err);
            check("valid", frame_valid, m_valid);
            check("overrun", overrun, m_ovr);
`ifdef BLANK_DETECT_EN
            check("blank", frame_blank, m_blk);
`endif
            if (overrun) ovr_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic show(input int d, input logic [6:0] p, input int n);
        seg_n   = p;
        dig_sel = 4'(1 << d);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        dig_sel = 4'h0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic scan(input logic [15:0] v);
        for (int d = 3; d >= 0; d--) show(d, glyph[v[4*d +: 4]], SC);
        dig_sel = 4'h0;
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        while (!frame_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(nm, frame_valid, 1);
    endtask

    task automatic consume(input string nm);
        @(posedge clk);
        #2 frame_ready = 1'b1;
        @(posedge clk);
        #2 frame_ready = 1'b0;
        @(negedge clk);
        check(nm, frame_valid, 0);
    endtask

    int o0;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_value", frame_value, 16'h0);
        check("rst_valid", frame_valid, 0);
        #2 rst_n = 1'b1;

        // reset mid-frame discards two accepted digits
        show(0, glyph[5], SC);
        show(1, glyph[6], SC);
        idle(2);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_value", frame_value, 16'h0);
        check("midrst_err", frame_err, 4'h0);
        check("midrst_valid", frame_valid, 0);
        rst_n = 1'b1;
        show(3, glyph[9], SC);
        show(2, glyph[8], SC);
        idle(10);
        check("partial_novalid", frame_valid, 0);
        show(1, glyph[7], SC);
        show(0, glyph[6], SC);
        dig_sel = 4'h0;
        wait_valid("t1_valid");
        check("t1_value", frame_value, 16'h9876);
        consume("t1_consume");

        // basic frame, held until consumed
        scan(16'h1234);
        wait_valid("t2_valid");
        check("t2_value", frame_value, 16'h1234);
        check("t2_err", frame_err, 4'h0);
        idle(5);
        check("t2_hold", frame_valid, 1);
        consume("t2_consume");

        // bad selections and a glitch accept nothing
        show(3, glyph[1], SC);
        show(2, glyph[2], SC);
        show(1, glyph[3], SC);
        seg_n = glyph[4];
        dig_sel = 4'b0011;
        repeat (10) @(posedge clk);
        idle(10);
        show(0, glyph[5], SC - 1);
        idle(10);
        check("glitch_novalid", frame_valid, 0);
        show(0, glyph[5], SC);
        dig_sel = 4'h0;
        wait_valid("t3_valid");
        check("t3_value", frame_value, 16'h1235);
        consume("t3_consume");

        // invalid glyph on digit 2
        show(3, glyph[15], SC);
        show(2, 7'b1111110, SC);
        show(1, glyph[0], SC);
        show(0, glyph[14], SC);
        dig_sel = 4'h0;
        wait_valid("t4_valid");
        check("t4_value", frame_value, 16'hF00E);
        check("t4_err", frame_err, 4'b0100);
        consume("t4_consume");

        // all-segments-off on digit 1
        show(3, glyph[1], SC);
        show(2, glyph[2], SC);
        show(1, 7'h7F, SC);
        show(0, glyph[4], SC);
        dig_sel = 4'h0;
        wait_valid("t4b_valid");
        check("t4b_value", frame_value, 16'h1204);
`ifdef BLANK_DETECT_EN
        check("t4b_err", frame_err, 4'b0000);
        check("t4b_blank", frame_blank, 4'b0010);
`else
        check("t4b_err", frame_err, 4'b0010);
`endif
        consume("t4b_consume");

        // overrun, then same-cycle replace
        scan(16'h1234);
        wait_valid("t5_valid");
        o0 = ovr_seen;
        scan(16'hABCD);
        idle(4);
        check("t5_ovr_count", ovr_seen - o0, 1);
        check("t5_keep", frame_value, 16'h1234);
        check("t5_valid", frame_valid, 1);
        o0 = ovr_seen;
        scan(16'hABCD);
        @(posedge clk);
        #2 frame_ready = 1'b1;
        @(posedge clk);
        #2 frame_ready = 1'b0;
        @(negedge clk);
        check("t5_replace", frame_value, 16'hABCD);
        check("t5_rvalid", frame_valid, 1);
        idle(3);
        check("t5_no_ovr", ovr_seen - o0, 0);
        consume("t5_consume");

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
